// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, shift-add multiply, optional restoring divide.
// Define ALU_SEQ_DIV_EN to build the divider datapath and DIV state (otherwise DIVU/REMU are reserved).
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             Zero,
  output logic             Neg,
  output logic             Overflow,
  output logic             Illegal,
  output logic             Busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
  typedef enum logic {S_IDLE, S_MUL} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_hi, r_lo;

  logic             w_accept, w_last;
  logic             w_start_mul, w_start_div, w_load_single, w_load_iter;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_sum, w_diff, w_sq, w_iq;
  logic             w_sovf, w_sill;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mhi, w_mlo;

  assign in_ready = (r_state == S_IDLE) & (~out_valid | out_ready);
  assign Busy     = (r_state != S_IDLE);
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Control: state transitions and which result source loads the output registers
  always_comb begin
    w_state_nxt   = r_state;
    w_start_mul   = 1'b0;
    w_start_div   = 1'b0;
    w_load_single = 1'b0;
    w_load_iter   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (Opcode == OP_MUL || Opcode == OP_MULHU) begin
            w_start_mul = 1'b1;
            w_state_nxt = S_MUL;
`ifdef ALU_SEQ_DIV_EN
          end else if ((Opcode == OP_DIVU || Opcode == OP_REMU) && (B != '0)) begin
            w_start_div = 1'b1;
            w_state_nxt = S_DIV;
`endif
          end else begin
            w_load_single = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (w_last) begin
          w_load_iter = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        if (w_last) begin
          w_load_iter = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_sh   = B[SHW-1:0];
  assign w_sum  = A + B;
  assign w_diff = A - B;

  // Single-cycle results, including divide-by-zero and reserved opcodes
  always_comb begin
    w_sq   = '0;
    w_sovf = 1'b0;
    w_sill = 1'b0;
    case (Opcode)
      OP_ADD: begin
        w_sq   = w_sum;
        w_sovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_sq   = w_diff;
        w_sovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  w_sq = A & B;
      OP_OR:   w_sq = A | B;
      OP_XOR:  w_sq = A ^ B;
      OP_SLL:  w_sq = A << w_sh;
      OP_SRL:  w_sq = A >> w_sh;
      OP_SRA:  w_sq = WIDTH'($signed(A) >>> w_sh);
      OP_SLT:  w_sq = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_sq = {{(WIDTH-1){1'b0}}, (A < B)};
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU: w_sq = '1;
      OP_REMU: w_sq = A;
`endif
      default: w_sill = 1'b1;
    endcase
  end

  // Shift-add multiply step: {r_hi, r_lo} holds partial product and remaining multiplier
  assign w_madd = {1'b0, r_hi} + ({(WIDTH+1){r_lo[0]}} & {1'b0, r_a});
  assign w_mhi  = w_madd[WIDTH:1];
  assign w_mlo  = {w_madd[0], r_lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   w_dshift;
  logic [WIDTH-1:0] w_dsub, w_dhi, w_dlo;
  logic             w_dok;

  // Restoring divide step: r_hi = partial remainder, r_lo = dividend shifting into quotient
  assign w_dshift = {r_hi, r_lo[WIDTH-1]};
  assign w_dok    = (w_dshift >= {1'b0, r_a});
  assign w_dsub   = w_dshift[WIDTH-1:0] - r_a;
  assign w_dhi    = w_dok ? w_dsub : w_dshift[WIDTH-1:0];
  assign w_dlo    = {r_lo[WIDTH-2:0], w_dok};
`endif

  always_comb begin
    case (r_op)
      OP_MULHU: w_iq = w_mhi;
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU:  w_iq = w_dlo;
      OP_REMU:  w_iq = w_dhi;
`endif
      default:  w_iq = w_mlo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_start_mul) begin
      r_cnt <= '0;
      r_op  <= Opcode;
      r_a   <= A;
      r_hi  <= '0;
      r_lo  <= B;
`ifdef ALU_SEQ_DIV_EN
    end else if (w_start_div) begin
      r_cnt <= '0;
      r_op  <= Opcode;
      r_a   <= B;
      r_hi  <= '0;
      r_lo  <= A;
    end else if (r_state == S_DIV) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      r_hi  <= w_dhi;
      r_lo  <= w_dlo;
`endif
    end else if (r_state == S_MUL) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      r_hi  <= w_mhi;
      r_lo  <= w_mlo;
    end
  end

  // Output registers hold until the consumer takes them
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Q         <= '0;
      Zero      <= 1'b0;
      Neg       <= 1'b0;
      Overflow  <= 1'b0;
      Illegal   <= 1'b0;
    end else if (w_load_single) begin
      out_valid <= 1'b1;
      Q         <= w_sq;
      Zero      <= (w_sq == '0);
      Neg       <= w_sq[WIDTH-1];
      Overflow  <= w_sovf;
      Illegal   <= w_sill;
    end else if (w_load_iter) begin
      out_valid <= 1'b1;
      Q         <= w_iq;
      Zero      <= (w_iq == '0);
      Neg       <= w_iq[WIDTH-1];
      Overflow  <= 1'b0;
      Illegal   <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): vector table plus backpressure, throughput and reset-abort sequences.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B, Q;
  logic [3:0]  Opcode;
  logic        out_valid, out_ready;
  logic        Zero, Neg, Overflow, Illegal, Busy;

  int n_tot = 0;
  int n_bad = 0;

`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Opcode(Opcode), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .Zero(Zero), .Neg(Neg), .Overflow(Overflow), .Illegal(Illegal), .Busy(Busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  fl;   // {Zero, Neg, Overflow, Illegal}
    int          lat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] q, input logic [3:0] fl, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.q = q; v.fl = fl; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Issue one op (out_ready assumed high); returns result, flags, latency and busy/in_ready behaviour
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [3:0] fl, output int lat,
                       output bit busy_ok);
    in_valid = 1'b1; Opcode = op; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b; Opcode = 4'd0;
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!Busy || in_ready) busy_ok = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end
    q  = Q;
    fl = {Zero, Neg, Overflow, Illegal};
  endtask

  logic [31:0] rq;
  logic [3:0]  rfl;
  int          rlat;
  bit          rbusy;
  int          ov_seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Opcode = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_q", 64'(Q), 64'd0);
    check("rst_flags", 64'({Zero, Neg, Overflow, Illegal, Busy}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    vq.push_back(mk(4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0110, 1));
    vq.push_back(mk(4'd0,  32'h80000000, 32'h80000000, 32'h0,        4'b1010, 1));
    vq.push_back(mk(4'd1,  32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0010, 1));
    vq.push_back(mk(4'd1,  32'h0,        32'h1,        32'hFFFFFFFF, 4'b0100, 1));
    vq.push_back(mk(4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 1));
    vq.push_back(mk(4'd3,  32'h0F,       32'hF0,       32'hFF,       4'b0000, 1));
    vq.push_back(mk(4'd4,  32'h12345678, 32'h12345678, 32'h0,        4'b1000, 1));
    vq.push_back(mk(4'd5,  32'h1,        32'h21,       32'h2,        4'b0000, 1));
    vq.push_back(mk(4'd6,  32'h80000000, 32'h1F,       32'h1,        4'b0000, 1));
    vq.push_back(mk(4'd7,  32'hFFFFFFF8, 32'h22,       32'hFFFFFFFE, 4'b0100, 1));
    vq.push_back(mk(4'd7,  32'h7FFFFFF0, 32'h4,        32'h07FFFFFF, 4'b0000, 1));
    vq.push_back(mk(4'd8,  32'hFFFFFFFB, 32'h3,        32'h1,        4'b0000, 1));
    vq.push_back(mk(4'd9,  32'hFFFFFFFB, 32'h3,        32'h0,        4'b1000, 1));
    vq.push_back(mk(4'd14, 32'h5,        32'h6,        32'h0,        4'b1001, 1));
    vq.push_back(mk(4'd15, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1001, 1));
    vq.push_back(mk(4'd10, 32'h10000,    32'h10000,    32'h0,        4'b1000, 33));
    vq.push_back(mk(4'd11, 32'h10000,    32'h10000,    32'h1,        4'b0000, 33));
    vq.push_back(mk(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        4'b0000, 33));
    vq.push_back(mk(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 33));
    vq.push_back(mk(4'd10, 32'h7,        32'h6,        32'h2A,       4'b0000, 33));
    vq.push_back(mk(4'd12, 32'd100, 32'd7,   DIV_ON ? 32'd14 : 32'd0, DIV_ON ? 4'b0000 : 4'b1001, DIV_ON ? 33 : 1));
    vq.push_back(mk(4'd13, 32'd100, 32'd7,   DIV_ON ? 32'd2  : 32'd0, DIV_ON ? 4'b0000 : 4'b1001, DIV_ON ? 33 : 1));
    vq.push_back(mk(4'd12, 32'd5,   32'd0,   DIV_ON ? 32'hFFFFFFFF : 32'd0, DIV_ON ? 4'b0100 : 4'b1001, 1));
    vq.push_back(mk(4'd13, 32'd5,   32'd0,   DIV_ON ? 32'd5  : 32'd0, DIV_ON ? 4'b0000 : 4'b1001, 1));
    vq.push_back(mk(4'd12, 32'hFFFFFFFF, 32'd1, DIV_ON ? 32'hFFFFFFFF : 32'd0, DIV_ON ? 4'b0100 : 4'b1001, DIV_ON ? 33 : 1));
    vq.push_back(mk(4'd13, 32'd7,   32'd100, DIV_ON ? 32'd7  : 32'd0, DIV_ON ? 4'b0000 : 4'b1001, DIV_ON ? 33 : 1));

    foreach (vq[i]) begin
      check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      do_op(vq[i].op, vq[i].a, vq[i].b, rq, rfl, rlat, rbusy);
      check($sformatf("v%0d_op%0d_q", i, vq[i].op), 64'(rq), 64'(vq[i].q));
      check($sformatf("v%0d_op%0d_flags", i, vq[i].op), 64'(rfl), 64'(vq[i].fl));
      check($sformatf("v%0d_op%0d_lat", i, vq[i].op), 64'(rlat), 64'(vq[i].lat));
      if (vq[i].lat > 1) check($sformatf("v%0d_busy_noready", i), 64'(rbusy), 64'd1);
    end
    @(posedge clk); #1;
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: ADD 15+10 held while a second op waits
    out_ready = 1'b0;
    in_valid = 1'b1; Opcode = 4'd0; A = 32'd15; B = 32'd10;
    @(posedge clk); #1;
    A = 32'd1; B = 32'd2;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_q", k), 64'(Q), 64'd25);
      check($sformatf("bp%0d_valid_ready", k), 64'({out_valid, in_ready}), 64'b10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_q", 64'(Q), 64'd3);
    check("bp_second_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check("bp_cleared", 64'(out_valid), 64'd0);

    // Throughput: one single-cycle op per clock
    in_valid = 1'b1; Opcode = 4'd0; A = 32'd1; B = 32'd1;
    @(posedge clk); #1;
    Opcode = 4'd1; A = 32'd10; B = 32'd3;
    check("tp0_q", 64'({out_valid, Q}), {31'd0, 1'b1, 32'd2});
    @(posedge clk); #1;
    Opcode = 4'd4; A = 32'd5; B = 32'd3;
    check("tp1_q", 64'({out_valid, Q}), {31'd0, 1'b1, 32'd7});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("tp2_q", 64'({out_valid, Q}), {31'd0, 1'b1, 32'd6});
    @(posedge clk); #1;

    // Reset during MUL aborts it
    in_valid = 1'b1; Opcode = 4'd10; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(Busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy_after", 64'({Busy, out_valid, in_ready}), 64'b001);
    ov_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    check("abort_no_result", 64'(ov_seen), 64'd0);
    do_op(4'd0, 32'd1, 32'd1, rq, rfl, rlat, rbusy);
    check("post_abort_q", 64'(rq), 64'd2);
    check("post_abort_lat", 64'(rlat), 64'd1);

    // Reset wins over a simultaneous accept
    @(posedge clk); #1;
    in_valid = 1'b1; Opcode = 4'd0; A = 32'd4; B = 32'd4; rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    check("rst_prio", 64'({out_valid, Q}), 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
